// File: rtl/byte_unstriping_4l.sv
// byte_unstriping_4l: serialises a 4-lane word (lane 0 first) into one byte stream under ready/valid
module byte_unstriping_4l #(
    parameter int DATA_W = 8
) (
    input  logic              clkf,
    input  logic              reset,
    input  logic              in_valid0,
    input  logic              in_valid1,
    input  logic              in_valid2,
    input  logic              in_valid3,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              lane_err
);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state, state_next;
    logic [DATA_W-1:0] buffer [4];
    logic [1:0] idx;
    logic [2:0] cnt, pat_cnt;
    logic [3:0] v;
    logic legal, last, capture, illegal, advance;
    assign v = {in_valid3, in_valid2, in_valid1, in_valid0};
    // only contiguous-from-lane-0 patterns are legal; count is the number of valid lanes
    always_comb begin
        pat_cnt = v == 4'b0001 ? 3'd1 :
                  v == 4'b0011 ? 3'd2 :
                  v == 4'b0111 ? 3'd3 :
                  v == 4'b1111 ? 3'd4 : 3'd0;
        legal = pat_cnt != 3'd0;
    end
    // accepting the last byte frees the buffer in the same cycle, so in_ready follows out_ready
    always_comb begin
        last = state == DRAIN && {1'b0, idx} == cnt - 3'd1;
        in_ready = reset && (state == IDLE || (last && out_ready));
        capture = in_ready && legal;
        illegal = in_ready && v != 4'b0000 && !legal;
        advance = state == DRAIN && out_ready && !last;
        state_next = capture ? DRAIN : (last && out_ready) ? IDLE : state;
    end
    // state register
    always_ff @(posedge clkf) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end
    // holding buffer, read index and registered output byte
    always_ff @(posedge clkf) begin
        if (!reset) begin
            buffer <= '{default: '0};
            idx <= 2'd0;
            cnt <= 3'd0;
            out_valid <= 1'b0;
            out_data <= '0;
            lane_err <= 1'b0;
        end else begin
            lane_err <= illegal;
            out_valid <= state_next == DRAIN;
            if (capture) begin
                buffer[0] <= in_data0;
                buffer[1] <= in_data1;
                buffer[2] <= in_data2;
                buffer[3] <= in_data3;
                cnt <= pat_cnt;
                idx <= 2'd0;
                out_data <= in_data0;
            end else if (advance) begin
                idx <= idx + 2'd1;
                out_data <= buffer[idx + 2'd1];
            end
        end
    end
endmodule

// File: tb/tb_byte_unstriping_4l.sv
// tb_byte_unstriping_4l: scoreboard bench for the 4-lane byte un-striper
module tb_byte_unstriping_4l;
    logic clkf = 1'b0;
    logic reset;
    logic in_valid0, in_valid1, in_valid2, in_valid3;
    logic [7:0] in_data0, in_data1, in_data2, in_data3;
    logic in_ready, out_valid, out_ready, lane_err;
    logic [7:0] out_data;
    logic [7:0] sb [$];
    int checks = 0;
    int failures = 0;

    byte_unstriping_4l #(.DATA_W(8)) dut (
        .clkf(clkf), .reset(reset),
        .in_valid0(in_valid0), .in_valid1(in_valid1), .in_valid2(in_valid2), .in_valid3(in_valid3),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .lane_err(lane_err)
    );

    always #5 clkf = ~clkf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pattern_count(input logic [3:0] v);
        return v == 4'b0001 ? 1 : v == 4'b0011 ? 2 : v == 4'b0111 ? 3 : v == 4'b1111 ? 4 : 0;
    endfunction

    task automatic set_word(input logic [3:0] v, input logic [31:0] d);
        {in_valid3, in_valid2, in_valid1, in_valid0} = v;
        {in_data3, in_data2, in_data1, in_data0} = d;
    endtask

    // scoreboard: pop on every output handshake, push the valid lanes on every legal capture
    always @(negedge clkf) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("spurious", {31'd0, out_valid}, 32'd0);
                else check("sb_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
            end
            if (in_ready) begin
                automatic int n = pattern_count({in_valid3, in_valid2, in_valid1, in_valid0});
                automatic logic [7:0] d [4] = '{in_data0, in_data1, in_data2, in_data3};
                for (int i = 0; i < n; i++) sb.push_back(d[i]);
            end
        end
    end

    task automatic send(input logic [3:0] v, input logic [31:0] d);
        int k;
        set_word(v, d);
        k = 0;
        @(negedge clkf);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge clkf);
        end
        if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clkf);
        #1 set_word(4'b0000, 32'd0);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        @(negedge clkf);
        while ((sb.size() != 0 || out_valid) && k < 50) begin
            k++;
            @(negedge clkf);
        end
        check("drain_timeout", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp3 [7];
        logic [6:0] rdy3;
        reset = 1'b0;
        out_ready = 1'b1;
        set_word(4'b1111, 32'h44332211);
        repeat (2) begin
            @(negedge clkf);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        end
        check("rst_lane_err", {31'd0, lane_err}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        @(posedge clkf);
        #1 reset = 1'b1;
        @(negedge clkf);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clkf);
        #1 set_word(4'b0000, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clkf);
            check("t1_valid", {31'd0, out_valid}, 32'd1);
            check("t1_data", {24'd0, out_data}, 32'h11 * (i + 1));
            check("t1_in_ready", {31'd0, in_ready}, (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clkf);
        check("t1_done", {31'd0, out_valid}, 32'd0);

        @(posedge clkf);
        #1 set_word(4'b0011, 32'h0000A1A0);
        @(negedge clkf);
        check("t2_in_ready0", {31'd0, in_ready}, 32'd1);
        @(posedge clkf);
        #1 set_word(4'b0001, 32'h000000B0);
        @(negedge clkf);
        check("t2_a0", {24'd0, out_data}, 32'hA0);
        check("t2_in_ready_a0", {31'd0, in_ready}, 32'd0);
        @(negedge clkf);
        check("t2_a1", {24'd0, out_data}, 32'hA1);
        check("t2_in_ready_a1", {31'd0, in_ready}, 32'd1);
        @(posedge clkf);
        #1 set_word(4'b0000, 32'd0);
        @(negedge clkf);
        check("t2_b0_valid", {31'd0, out_valid}, 32'd1);
        check("t2_b0", {24'd0, out_data}, 32'hB0);
        @(negedge clkf);
        check("t2_done", {31'd0, out_valid}, 32'd0);

        exp3 = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h04};
        rdy3 = 7'b1011001;
        @(posedge clkf);
        #1 set_word(4'b1111, 32'h04030201);
        @(posedge clkf);
        #1 set_word(4'b0000, 32'd0);
        for (int k = 0; k < 7; k++) begin
            out_ready = rdy3[k];
            @(negedge clkf);
            check("t3_valid", {31'd0, out_valid}, 32'd1);
            check("t3_data", {24'd0, out_data}, {24'd0, exp3[k]});
            check("t3_in_ready", {31'd0, in_ready}, (k == 6) ? 32'd1 : 32'd0);
            @(posedge clkf);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clkf);
        check("t3_done", {31'd0, out_valid}, 32'd0);

        @(posedge clkf);
        #1 set_word(4'b0101, 32'h99887766);
        @(negedge clkf);
        check("t4_pre_err", {31'd0, lane_err}, 32'd0);
        @(posedge clkf);
        #1 set_word(4'b0000, 32'd0);
        @(negedge clkf);
        check("t4_err", {31'd0, lane_err}, 32'd1);
        check("t4_valid", {31'd0, out_valid}, 32'd0);
        check("t4_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clkf);
        check("t4_err_clear", {31'd0, lane_err}, 32'd0);
        send(4'b1111, 32'h64636261);
        wait_drain();

        @(posedge clkf);
        #1 set_word(4'b0001, 32'h0000005A);
        @(posedge clkf);
        #1 set_word(4'b1010, 32'hDEADBEEF);
        @(negedge clkf);
        check("t5_data", {24'd0, out_data}, 32'h5A);
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clkf);
        #1 set_word(4'b0000, 32'd0);
        @(negedge clkf);
        check("t5_err", {31'd0, lane_err}, 32'd1);
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clkf);
        check("t5_err_clear", {31'd0, lane_err}, 32'd0);

        @(posedge clkf);
        #1 set_word(4'b1111, 32'hC3C2C1C0);
        @(posedge clkf);
        #1 set_word(4'b0000, 32'd0);
        @(negedge clkf);
        check("t6_c0", {24'd0, out_data}, 32'hC0);
        @(negedge clkf);
        check("t6_c1", {24'd0, out_data}, 32'hC1);
        @(posedge clkf);
        #1 reset = 1'b0;
        sb.delete();
        @(posedge clkf);
        #1 reset = 1'b1;
        @(negedge clkf);
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_data", {24'd0, out_data}, 32'd0);
        repeat (3) begin
            @(negedge clkf);
            check("t6_quiet", {31'd0, out_valid}, 32'd0);
        end
        check("sb_left", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
